// File: rtl/obi_cache_client.sv
// OBI manager that turns one host GET/PUT/DELETE into KEY/DATA/OPERATION writes, STATUS polling and DATA reads.
// Optional poll timeout: define OBI_CLIENT_TIMEOUT_EN to abort after POLL_LIMIT busy STATUS reads.
module obi_cache_client #(
    parameter int                      ARCHITECTURE = 32,
    parameter int                      KEY_WIDTH    = 16,
    parameter int                      VALUE_WIDTH  = 64,
    parameter logic [ARCHITECTURE-1:0] BASE_ADDR    = '0,
    parameter int                      POLL_LIMIT   = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [KEY_WIDTH-1:0]    cmd_key_i,
    input  logic [VALUE_WIDTH-1:0]  cmd_value_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_hit_o,
    output logic [VALUE_WIDTH-1:0]  rsp_value_o,
    output logic                    rsp_err_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ARCHITECTURE-1:0] obi_addr_o,
    output logic                    obi_we_o,
    output logic [3:0]              obi_be_o,
    output logic [ARCHITECTURE-1:0] obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [ARCHITECTURE-1:0] obi_rdata_i,
    input  logic                    obi_err_i
);
    localparam logic [1:0] OP_GET = 2'd1;
    localparam logic [1:0] OP_PUT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_KEY, S_WR_DLO, S_WR_DHI, S_WR_OP, S_POLL, S_RD_LO, S_RD_HI, S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    rwait_q, rwait_d;
    logic [1:0]              op_q, op_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [VALUE_WIDTH-1:0]  value_q, value_d;
    logic                    hit_q, hit_d, err_q, err_d;
    logic [ARCHITECTURE-1:0] lo_q, lo_d, hi_q, hi_d;
    logic                    req_q, req_d, we_q, we_d;
    logic [ARCHITECTURE-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic                    ready_q, ready_d, rsp_valid_q, rsp_valid_d;
`ifdef OBI_CLIENT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(POLL_LIMIT + 1) > 8) ? $clog2(POLL_LIMIT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        rwait_d = rwait_q;
        op_d    = op_q;
        key_d   = key_q;
        value_d = value_q;
        hit_d   = hit_q;
        err_d   = err_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
`ifdef OBI_CLIENT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    op_d    = cmd_op_i;
                    key_d   = cmd_key_i;
                    value_d = cmd_value_i;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    lo_d    = '0;
                    hi_d    = '0;
                    rwait_d = 1'b0;
                    if (cmd_op_i == 2'd0) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WR_KEY;
                    end
                end
            end
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: begin
                // Bus states: request phase until grant, then wait for the response.
                if (!rwait_q) begin
                    if (obi_gnt_i) rwait_d = 1'b1;
                end else if (obi_rvalid_i) begin
                    rwait_d = 1'b0;
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        hit_d   = 1'b0;
                        lo_d    = '0;
                        hi_d    = '0;
                        state_d = S_RESP;
                    end else begin
                        case (state_q)
                            S_WR_KEY: state_d = (op_q == OP_PUT) ? S_WR_DLO : S_WR_OP;
                            S_WR_DLO: state_d = S_WR_DHI;
                            S_WR_DHI: state_d = S_WR_OP;
                            S_WR_OP: begin
                                state_d = S_POLL;
`ifdef OBI_CLIENT_TIMEOUT_EN
                                cnt_d   = '0;
`endif
                            end
                            S_POLL: begin
                                if (obi_rdata_i[0]) begin
`ifdef OBI_CLIENT_TIMEOUT_EN
                                    if (int'(cnt_q) >= POLL_LIMIT - 1) begin
                                        err_d   = 1'b1;
                                        hit_d   = 1'b0;
                                        state_d = S_RESP;
                                    end else begin
                                        cnt_d = cnt_q + 1'b1;
                                    end
`endif
                                end else begin
                                    hit_d   = obi_rdata_i[1];
                                    state_d = (op_q == OP_GET && obi_rdata_i[1]) ? S_RD_LO : S_RESP;
                                end
                            end
                            S_RD_LO: begin
                                lo_d    = obi_rdata_i;
                                state_d = S_RD_HI;
                            end
                            S_RD_HI: begin
                                hi_d    = obi_rdata_i;
                                state_d = S_RESP;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase

        // Bus outputs follow the next state, so they hold steady for as long as the state does.
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            S_WR_KEY: begin
                req_d = 1'b1; we_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(4);
                wdata_d = ARCHITECTURE'(key_d);
            end
            S_WR_DLO: begin
                req_d = 1'b1; we_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(8);
                wdata_d = value_d[ARCHITECTURE-1:0];
            end
            S_WR_DHI: begin
                req_d = 1'b1; we_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(12);
                wdata_d = value_d[VALUE_WIDTH-1:ARCHITECTURE];
            end
            S_WR_OP: begin
                req_d = 1'b1; we_d = 1'b1; addr_d = BASE_ADDR;
                wdata_d = ARCHITECTURE'(op_d);
            end
            S_POLL:  begin req_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(16); end
            S_RD_LO: begin req_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(8); end
            S_RD_HI: begin req_d = 1'b1; addr_d = BASE_ADDR + ARCHITECTURE'(12); end
            default: ;
        endcase
        req_d       = req_d && !rwait_d;
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rwait_q     <= 1'b0;
            op_q        <= '0;
            key_q       <= '0;
            value_q     <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef OBI_CLIENT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rwait_q     <= rwait_d;
            op_q        <= op_d;
            key_q       <= key_d;
            value_q     <= value_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef OBI_CLIENT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_err_o   = err_q;
    assign rsp_value_o = {hi_q, lo_q};
    assign obi_req_o   = req_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = 4'hF;
    assign obi_wdata_o = wdata_q;
endmodule

// File: tb/tb_obi_cache_client.sv
// Directed bench for obi_cache_client: behavioural OBI subordinate with optional grant stalls and error injection.
module tb_obi_cache_client;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready_o;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_key = '0;
    logic [63:0] cmd_value = '0;
    logic        rsp_valid_o, rsp_ready = 1'b0, rsp_hit_o, rsp_err_o;
    logic [63:0] rsp_value_o;
    logic        obi_req_o, obi_gnt = 1'b0, obi_we_o, obi_rvalid = 1'b0, obi_err = 1'b0;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata = '0;
    logic [3:0]  obi_be_o;

    obi_cache_client #(.ARCHITECTURE(32), .KEY_WIDTH(16), .VALUE_WIDTH(64),
                       .BASE_ADDR(32'h0), .POLL_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .cmd_key_i(cmd_key), .cmd_value_i(cmd_value),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit_o),
        .rsp_value_o(rsp_value_o), .rsp_err_o(rsp_err_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] status_q[$];
    logic [31:0] status_dflt = '0, rd_lo = '0, rd_hi = '0, err_addr = '0;
    bit          stall_mode = 0, err_en = 0;
    int          n_status = 0;

    // Subordinate: grants at negedge (possibly after a stall), responds one cycle after the grant.
    int          stall = 0;
    bit          pend = 0, pend_err = 0, holding = 0;
    logic [31:0] pend_data = '0, prev_addr = '0, prev_wdata = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            obi_gnt = 0; obi_rvalid = 0; obi_err = 0; pend = 0; holding = 0; stall = 0;
        end else begin
            obi_rvalid = 0; obi_err = 0; obi_rdata = '0;
            if (pend) begin
                obi_rvalid = 1; obi_rdata = pend_data; obi_err = pend_err; pend = 0;
            end
            obi_gnt = 0;
            if (obi_req_o) begin
                if (holding) begin
                    chk("addr_stable", 64'(obi_addr_o), 64'(prev_addr));
                    chk("wdata_stable", 64'(obi_wdata_o), 64'(prev_wdata));
                end
                if (stall > 0) begin
                    stall--;
                    holding = 1; prev_addr = obi_addr_o; prev_wdata = obi_wdata_o;
                end else begin
                    obi_gnt = 1; holding = 0; pend = 1;
                    txq.push_back('{obi_we_o, obi_addr_o, obi_wdata_o});
                    pend_err = err_en && (obi_addr_o == err_addr);
                    pend_data = '0;
                    if (!obi_we_o) begin
                        case (obi_addr_o)
                            32'h10: begin
                                n_status++;
                                pend_data = (status_q.size() > 0) ? status_q.pop_front() : status_dflt;
                            end
                            32'h08: pend_data = rd_lo;
                            32'h0C: pend_data = rd_hi;
                            default: pend_data = '0;
                        endcase
                    end
                    stall = stall_mode ? int'($urandom_range(0, 5)) : 0;
                end
            end else begin
                holding = 0;
            end
        end
    end

    logic        r_hit, r_err;
    logic [63:0] r_val;
    int          lat;

    task automatic start_test();
        txq.delete(); status_q.delete(); n_status = 0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val,
                           input int hold);
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready_o), 1);
        cmd_valid = 1; cmd_op = op; cmd_key = key; cmd_value = val;
        lat = 0;
        do begin
            @(negedge clk);
            cmd_valid = 0;
            lat++;
        end while (!rsp_valid_o && lat < 3000);
        chk("rsp_valid", 64'(rsp_valid_o), 1);
        r_hit = rsp_hit_o; r_err = rsp_err_o; r_val = rsp_value_o;
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_valid_held", 64'(rsp_valid_o), 1);
            chk("rsp_stable", {rsp_value_o[61:0], rsp_hit_o, rsp_err_o}, {r_val[61:0], r_hit, r_err});
            chk("cmd_ready_busy", 64'(cmd_ready_o), 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_dropped", 64'(rsp_valid_o), 0);
        chk("cmd_ready_back", 64'(cmd_ready_o), 1);
    endtask

    task automatic chk_txn(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        if (i < txq.size()) begin
            chk("txn_we", 64'(txq[i].we), 64'(we));
            chk("txn_addr", 64'(txq[i].addr), 64'(addr));
            if (we) chk("txn_wdata", 64'(txq[i].wdata), 64'(wd));
        end else begin
            chk("txn_present", 64'(txq.size()), 64'(i + 1));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rst_req", 64'(obi_req_o), 0);
        chk("rst_be", 64'(obi_be_o), 64'hF);
        chk("rst_value", rsp_value_o, 0);
        rst_n = 1;

        // PUT, zero-wait
        start_test(); status_q.push_back(32'h0);
        run_cmd(2'd2, 16'h1234, 64'hDEADBEEF_CAFEF00D, 0);
        chk("put_lat", 64'(lat), 11);
        chk("put_ntxn", 64'(txq.size()), 5);
        chk_txn(0, 1, 32'h04, 32'h1234);
        chk_txn(1, 1, 32'h08, 32'hCAFEF00D);
        chk_txn(2, 1, 32'h0C, 32'hDEADBEEF);
        chk_txn(3, 1, 32'h00, 32'h2);
        chk_txn(4, 0, 32'h10, 32'h0);
        chk("put_rsp", {r_val[61:0], r_hit, r_err}, 0);

        // GET hit after two busy polls
        start_test(); status_q = '{32'h1, 32'h1, 32'h6};
        rd_lo = 32'hCAFEF00D; rd_hi = 32'hDEADBEEF;
        run_cmd(2'd1, 16'h1234, 64'h0, 0);
        chk("get_lat", 64'(lat), 15);
        chk("get_npoll", 64'(n_status), 3);
        chk("get_ntxn", 64'(txq.size()), 7);
        chk_txn(1, 1, 32'h00, 32'h1);
        chk_txn(5, 0, 32'h08, 32'h0);
        chk_txn(6, 0, 32'h0C, 32'h0);
        chk("get_hit", 64'(r_hit), 1);
        chk("get_err", 64'(r_err), 0);
        chk("get_value", r_val, 64'hDEADBEEF_CAFEF00D);

        // GET miss
        start_test(); status_q.push_back(32'h0);
        run_cmd(2'd1, 16'h0042, 64'h0, 0);
        chk("miss_lat", 64'(lat), 7);
        chk("miss_ntxn", 64'(txq.size()), 3);
        chk("miss_rsp", {r_val[61:0], r_hit, r_err}, 0);

        // DELETE
        start_test(); status_q.push_back(32'h2);
        run_cmd(2'd3, 16'h0042, 64'h0, 0);
        chk("del_lat", 64'(lat), 7);
        chk("del_ntxn", 64'(txq.size()), 3);
        chk_txn(0, 1, 32'h04, 32'h0042);
        chk_txn(1, 1, 32'h00, 32'h3);
        chk("del_value", r_val, 0);
        chk("del_err", 64'(r_err), 0);

        // Grant stalls and a slow host on PUT and GET hit
        stall_mode = 1;
        start_test(); status_q.push_back(32'h0);
        run_cmd(2'd2, 16'hBEEF, 64'h01234567_89ABCDEF, 10);
        chk("stall_put_ntxn", 64'(txq.size()), 5);
        chk_txn(1, 1, 32'h08, 32'h89ABCDEF);
        chk_txn(2, 1, 32'h0C, 32'h01234567);
        chk("stall_put_rsp", {r_val[61:0], r_hit, r_err}, 0);
        start_test(); status_q = '{32'h1, 32'h6};
        rd_lo = 32'h11112222; rd_hi = 32'h33334444;
        run_cmd(2'd1, 16'hBEEF, 64'h0, 10);
        chk("stall_get_value", r_val, 64'h33334444_11112222);
        chk("stall_get_hit", 64'(r_hit), 1);
        stall_mode = 0;

        // Error response on the KEY write
        start_test(); err_en = 1; err_addr = 32'h04;
        run_cmd(2'd1, 16'h0007, 64'h0, 0);
        err_en = 0;
        chk("err_ntxn", 64'(txq.size()), 1);
        chk("err_flag", 64'(r_err), 1);
        chk("err_hit", 64'(r_hit), 0);

        // Reserved op 0
        start_test();
        run_cmd(2'd0, 16'h0007, 64'h0, 0);
        chk("op0_ntxn", 64'(txq.size()), 0);
        chk("op0_lat", 64'(lat), 1);
        chk("op0_err", 64'(r_err), 1);
        chk("op0_value", r_val, 0);

`ifdef OBI_CLIENT_TIMEOUT_EN
        start_test(); status_dflt = 32'h1;
        run_cmd(2'd1, 16'h0009, 64'h0, 0);
        chk("to_npoll", 64'(n_status), 4);
        chk("to_err", 64'(r_err), 1);
        chk("to_hit", 64'(r_hit), 0);
        status_dflt = 32'h0;
`endif

        // Reset while polling a permanently busy cache
        start_test(); status_dflt = 32'h1;
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'd3; cmd_key = 16'h0055;
        @(negedge clk);
        cmd_valid = 0;
        begin
            int n = 0;
            while (!(n_status >= 2 && obi_req_o) && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rstpoll_req_before", 64'(obi_req_o), 1);
        #2 rst_n = 0;
        #1;
        chk("rstpoll_req", 64'(obi_req_o), 0);
        chk("rstpoll_ready", 64'(cmd_ready_o), 1);
        chk("rstpoll_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rstpoll_addr", 64'(obi_addr_o), 0);
        status_dflt = 32'h0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("rstpoll_no_rsp", 64'(rsp_valid_o), 0);
        chk("rstpoll_idle_req", 64'(obi_req_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/obi_cache_client.md
Name: obi_cache_client

Overview:
OBI manager (initiator) that drives the key-value cache's OBI subordinate register interface on behalf of a simple host command port. One host command (GET/PUT/DELETE) becomes a sequence of single-outstanding OBI register writes, status polling until the cache is not busy, then result reads. Sits in front of the cache top in SoC and test fixtures and replaces hand-written OBI sequences.

Parameters:
ARCHITECTURE, 32, OBI address/data width
KEY_WIDTH, 16, key width; must be <= ARCHITECTURE; zero-extended on the bus
VALUE_WIDTH, 64, value width; fixed at 2*ARCHITECTURE (low word at DATA_LO, high word at DATA_HI)
BASE_ADDR, 32'h0, cache register base address
POLL_LIMIT, 255, maximum STATUS reads per command (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  client idle; accepts a command
cmd_op_i  in  2  1=GET, 2=PUT, 3=DELETE; 0 is reserved
cmd_key_i  in  KEY_WIDTH  key
cmd_value_i  in  VALUE_WIDTH  PUT value
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  host accepts result
rsp_hit_o  out  1  cache hit (STATUS bit1)
rsp_value_o  out  VALUE_WIDTH  GET value; 0 on miss, PUT, or DELETE
rsp_err_o  out  1  OBI error, reserved op, or timeout
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ARCHITECTURE  byte address
obi_we_o  out  1  write enable
obi_be_o  out  4  byte enables; always 4'hF
obi_wdata_o  out  ARCHITECTURE  write data
obi_rvalid_i  in  1  response valid
obi_rdata_i  in  ARCHITECTURE  read data
obi_err_i  in  1  response error, sampled with rvalid

Behaviour:
- Register map as offsets from BASE_ADDR: 0x00 OPERATION (a write starts the op), 0x04 KEY, 0x08 DATA_LO, 0x0C DATA_HI, 0x10 STATUS (bit0 busy, bit1 hit, bit2 data_valid).
- Reset values: all outputs 0 except cmd_ready_o=1 and obi_be_o=4'hF. State is IDLE.
- Reset asserted mid-operation aborts at once. No response is produced, and obi_req_o drops asynchronously.
- Command handshake: a command is captured when cmd_valid_i && cmd_ready_o. cmd_ready_o=1 only in IDLE.
- Reserved op 0 produces no OBI traffic. The FSM goes to RESP next cycle with err=1, hit=0, value=0.
- OBI transaction rules:
  - obi_req_o and addr/we/wdata stay stable from assertion until the cycle with obi_gnt_i=1.
  - req deasserts the cycle after grant. The FSM then waits for obi_rvalid_i; rdata and err are sampled there.
  - At most one transaction outstanding. The next req is issued no earlier than the cycle after rvalid.
- FSM: IDLE -> WR_KEY -> [WR_DLO -> WR_DHI, PUT only] -> WR_OP -> POLL -> [RD_LO -> RD_HI, GET with hit only] -> RESP -> IDLE.
- WR_OP writes {30'b0, op}.
- POLL reads STATUS and repeats while bit0=1. When bit0=0, hit is latched from bit1.
- obi_err_i=1 on any response: latch err=1, skip the remaining transactions, go to RESP.
- RESP: rsp_valid_o=1, with all rsp_* held stable until rsp_ready_i. Return to IDLE the cycle after the handshake.
- Minimum latency with zero-wait grant/rvalid, from accept to rsp_valid_o:
  - DELETE or GET-miss with one poll: 3 transactions × 2 cycles + 1 = 7 cycles.
  - PUT: 11 cycles.
  - GET hit: 11 cycles.
- rsp_value_o = {rd_hi, rd_lo}. It is cleared to 0 on command accept.

Optional Feature:
OBI_CLIENT_TIMEOUT_EN:
- Defined: an 8-bit-min poll counter increments per STATUS read. When POLL_LIMIT reads have returned busy=1, go to RESP with err=1 and hit=0.
- Not defined: POLL repeats indefinitely, and err comes only from obi_err_i or op 0.

Test Plan:
- PUT key=0x1234, value=0xDEADBEEF_CAFEF00D, zero-wait slave, STATUS=0x0 -> OBI sequence is:
  - W 0x04=0x1234
  - W 0x08=0xCAFEF00D
  - W 0x0C=0xDEADBEEF
  - W 0x00=0x2
  - R 0x10
  - then rsp_valid with hit=0, err=0, value=0.
- GET key=0x1234, STATUS reads 0x1, 0x1, then 0x6; RD_LO=0xCAFEF00D, RD_HI=0xDEADBEEF -> three STATUS reads, then rsp hit=1, value=0xDEADBEEF_CAFEF00D.
- GET miss (STATUS=0x0) and DELETE -> no DATA reads; DELETE writes OPERATION=0x3; rsp hit=0, value=0.
- Random obi_gnt_i stalls of 0-5 cycles plus rsp_ready_i held low 10 cycles -> addr/wdata stable until grant, rsp_* stable, cmd_ready_o=0 until the response handshake.
- obi_err_i=1 on the KEY write -> no further OBI requests, rsp err=1. Separately, op=0 -> zero OBI requests, err=1.
- Reset mid-POLL -> outputs back to reset values next edge. With OBI_CLIENT_TIMEOUT_EN and POLL_LIMIT=4, STATUS stuck at 0x1 -> exactly 4 reads, err=1.
